// File: rtl/tinyriscv_pkg.sv
// Shared core definitions used by the fetch unit.
// Holds bus widths, the canonical NOP, the reset PC, the buffer entry layout
// and a word-alignment helper.
package tinyriscv_pkg;

    localparam int InstBus     = 32;
    localparam int InstAddrBus = 32;

    localparam logic [InstAddrBus-1:0] ZeroWord     = 32'h0000_0000;
    localparam logic [InstBus-1:0]     INST_NOP     = 32'h0000_0013;  // addi x0, x0, 0
    localparam logic [InstAddrBus-1:0] CpuResetAddr = 32'h0000_0000;

    // One instruction buffer entry: the fetched word and where it came from.
    typedef struct packed {
        logic [InstAddrBus-1:0] addr;
        logic [InstBus-1:0]     inst;
    } fetch_entry_t;

    function automatic logic [InstAddrBus-1:0] word_align(input logic [InstAddrBus-1:0] a);
        return {a[InstAddrBus-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/if_fifo.sv
// Small synchronous in-order FIFO used as the instruction buffer.
// Ports:
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   flush_i       : empties the FIFO on this edge (wins over push/pop)
//   push_i/data_i : write one entry
//   pop_i         : drop the head entry
//   data_o        : head entry, combinational from storage (undefined when empty)
//   empty_o/full_o/count_o : occupancy
// Pointers carry one extra wrap bit so full and empty are distinguishable.
module if_fifo #(
    parameter int Depth = 2,
    parameter int Width = 64
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     flush_i,
    input  logic                     push_i,
    input  logic [Width-1:0]         data_i,
    input  logic                     pop_i,
    output logic [Width-1:0]         data_o,
    output logic                     empty_o,
    output logic                     full_o,
    output logic [$clog2(Depth):0]   count_o
);

    localparam int PtrW = $clog2(Depth);

    logic [Width-1:0] mem [Depth];
    logic [PtrW:0]    wr_ptr;
    logic [PtrW:0]    rd_ptr;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push_i) wr_ptr <= wr_ptr + (PtrW+1)'(1);
            if (pop_i)  rd_ptr <= rd_ptr + (PtrW+1)'(1);
        end
    end

    // Storage needs no reset: entries are only observed once written.
    always_ff @(posedge clk_i) begin
        if (push_i && !flush_i) mem[wr_ptr[PtrW-1:0]] <= data_i;
    end

    assign count_o = wr_ptr - rd_ptr;
    assign empty_o = (wr_ptr == rd_ptr);
    assign full_o  = (count_o == (PtrW+1)'(Depth));
    assign data_o  = mem[rd_ptr[PtrW-1:0]];

endmodule

// File: rtl/if_fetch.sv
// Instruction fetch unit. Owns the PC, issues word fetches on the instruction
// bus, buffers returned words in order and hands inst/inst_addr pairs to decode.
// Ports:
//   clk_i, rst_ni              : clock, asynchronous active-low reset
//   jump_flag_i, jump_addr_i   : single-cycle redirect from ex and its target
//   ibus_req_o, ibus_addr_o    : fetch request and word-aligned address
//   ibus_gnt_i                 : request accepted this cycle
//   ibus_rvalid_i, ibus_rdata_i: in-order response
//   inst_o, inst_addr_o        : instruction to decode and its address
//   inst_valid_o, inst_ready_i : output handshake
//
// Handshakes: a bus request transfers on the cycle ibus_req_o && ibus_gnt_i;
// an ungranted request may change or drop the next cycle. An instruction
// transfers on the cycle inst_valid_o && inst_ready_i; while valid and not
// ready, inst_o/inst_addr_o hold. A redirect overrides both handshakes.
module if_fetch
    import tinyriscv_pkg::*;
#(
    parameter int                     Depth     = 2,
    parameter logic [InstAddrBus-1:0] ResetAddr = CpuResetAddr
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   jump_flag_i,
    input  logic [InstAddrBus-1:0] jump_addr_i,
    output logic                   ibus_req_o,
    output logic [InstAddrBus-1:0] ibus_addr_o,
    input  logic                   ibus_gnt_i,
    input  logic                   ibus_rvalid_i,
    input  logic [InstBus-1:0]     ibus_rdata_i,
    output logic [InstBus-1:0]     inst_o,
    output logic [InstAddrBus-1:0] inst_addr_o,
    output logic                   inst_valid_o,
    input  logic                   inst_ready_i
);

    localparam int            PtrW     = $clog2(Depth);
    localparam int            CntW     = PtrW + 1;
    localparam logic [CntW:0] DepthExt = (CntW+1)'(Depth);

    logic [InstAddrBus-1:0] pc;
    logic [CntW-1:0]        outstanding;
    logic [CntW-1:0]        discard;
    logic [CntW-1:0]        out_next;

    // Address of each granted request, consumed in order by its response
    // (stale responses consume their slot too).
    logic [InstAddrBus-1:0] addr_q [Depth];
    logic [CntW-1:0]        aq_wr;
    logic [CntW-1:0]        aq_rd;

    fetch_entry_t    fifo_wdata;
    fetch_entry_t    fifo_rdata;
    logic            fifo_push;
    logic            fifo_pop;
    logic            fifo_empty;
    logic            fifo_full;
    logic [CntW-1:0] fifo_count;

    logic            gnt_fire;
    logic [CntW:0]   in_use;
    logic [CntW:0]   limit;

    always_comb begin
        // A pop during a redirect is meaningless: the buffer is flushed anyway.
        fifo_pop = !fifo_empty && inst_ready_i && !jump_flag_i;

        // Every granted request owns a buffer slot until decode takes it. The
        // slot freed by this cycle's pop can be promised already, because its
        // response cannot arrive before the next edge; this keeps one fetch
        // per cycle with a two-entry buffer.
        in_use = {1'b0, outstanding} + {1'b0, fifo_count};
        limit  = DepthExt + {{CntW{1'b0}}, fifo_pop};

        // Gating with rst_ni keeps the request low while reset is held.
        ibus_req_o  = rst_ni && !jump_flag_i && (in_use < limit);
        ibus_addr_o = pc;
        gnt_fire    = ibus_req_o && ibus_gnt_i;

        // Responses arriving during a redirect are stale as well.
        fifo_push        = ibus_rvalid_i && (discard == '0) && !jump_flag_i;
        fifo_wdata.addr  = addr_q[aq_rd[PtrW-1:0]];
        fifo_wdata.inst  = ibus_rdata_i;

        out_next = outstanding + CntW'(gnt_fire) - CntW'(ibus_rvalid_i);

        inst_valid_o = !fifo_empty;
        inst_o       = fifo_empty ? INST_NOP : fifo_rdata.inst;
        inst_addr_o  = fifo_empty ? ZeroWord : fifo_rdata.addr;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pc          <= ResetAddr;
            outstanding <= '0;
            discard     <= '0;
            aq_wr       <= '0;
            aq_rd       <= '0;
        end else begin
            outstanding <= out_next;
            if (jump_flag_i) begin
                pc      <= word_align(jump_addr_i);
                // Everything still in flight after this edge belongs to the
                // old path, including a stale response consumed this cycle.
                discard <= out_next;
            end else begin
                if (gnt_fire) pc <= pc + 32'd4;
                if (ibus_rvalid_i && (discard != '0)) discard <= discard - CntW'(1);
            end
            if (gnt_fire)      aq_wr <= aq_wr + CntW'(1);
            if (ibus_rvalid_i) aq_rd <= aq_rd + CntW'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (gnt_fire) addr_q[aq_wr[PtrW-1:0]] <= pc;
    end

    if_fifo #(
        .Depth (Depth),
        .Width ($bits(fetch_entry_t))
    ) u_if_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .flush_i (jump_flag_i),
        .push_i  (fifo_push),
        .data_i  (fifo_wdata),
        .pop_i   (fifo_pop),
        .data_o  (fifo_rdata),
        .empty_o (fifo_empty),
        .full_o  (fifo_full),
        .count_o (fifo_count)
    );

    // The slot reservation makes both of these impossible on a compliant bus.
    always_ff @(posedge clk_i) begin
        if (rst_ni) begin
            assert (!(fifo_push && fifo_full))
                else $error("if_fetch: response pushed into a full buffer");
            assert (!(ibus_rvalid_i && (outstanding == '0)))
                else $error("if_fetch: response with nothing outstanding");
        end
    end

endmodule

// File: tb/tb_if_fetch.sv
// Directed bench for if_fetch with an in-order bus responder and an
// expected-instruction scoreboard.
module tb_if_fetch;
    import tinyriscv_pkg::*;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        jump_flag_i;
    logic [31:0] jump_addr_i;
    logic        ibus_req_o;
    logic [31:0] ibus_addr_o;
    logic        ibus_gnt_i;
    logic        ibus_rvalid_i;
    logic [31:0] ibus_rdata_i;
    logic [31:0] inst_o;
    logic [31:0] inst_addr_o;
    logic        inst_valid_o;
    logic        inst_ready_i;

    if_fetch dut (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .jump_flag_i   (jump_flag_i),
        .jump_addr_i   (jump_addr_i),
        .ibus_req_o    (ibus_req_o),
        .ibus_addr_o   (ibus_addr_o),
        .ibus_gnt_i    (ibus_gnt_i),
        .ibus_rvalid_i (ibus_rvalid_i),
        .ibus_rdata_i  (ibus_rdata_i),
        .inst_o        (inst_o),
        .inst_addr_o   (inst_addr_o),
        .inst_valid_o  (inst_valid_o),
        .inst_ready_i  (inst_ready_i)
    );

    // ---------------- clock ----------------
    always #5 clk_i = ~clk_i;

    // ---------------- bench state ----------------
    int          compared   = 0;
    int          mismatched = 0;
    logic [63:0] exp_q[$];      // {addr, inst} decode should see, in order
    logic [31:0] bus_q[$];      // granted addresses awaiting a response
    logic [31:0] model_pc;
    bit          resp_en;
    int          cyc;
    int          grants;
    int          pops;
    int          first_pop_cyc;
    logic [31:0] first_pop_addr;
    int          jump_cyc;

    // Memory contents seen by the bus: a fixed function of the address.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0] ^ 16'h5A5A, a[31:16] ^ a[15:0] ^ 16'h0C3F};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock cycle. Called at a negedge: drives inputs, samples 1 ns later,
    // updates bus model and scoreboard, then advances to the next negedge.
    task automatic cycle(input logic jump, input logic [31:0] jaddr,
                         input logic ready, input logic gnt);
        logic [63:0] e;
        jump_flag_i  = jump;
        jump_addr_i  = jaddr;
        inst_ready_i = ready;
        ibus_gnt_i   = gnt;
        if (resp_en && bus_q.size() > 0) begin
            ibus_rvalid_i = 1'b1;
            ibus_rdata_i  = mem_word(bus_q[0]);
        end else begin
            ibus_rvalid_i = 1'b0;
            ibus_rdata_i  = 32'h0;
        end
        #1;
        if (ibus_rvalid_i) void'(bus_q.pop_front());
        if (jump) chk("req_low_in_jump", {63'd0, ibus_req_o}, 64'd0);
        if (ibus_req_o && gnt) begin
            chk("fetch_addr", {32'd0, ibus_addr_o}, {32'd0, model_pc});
            bus_q.push_back(ibus_addr_o);
            exp_q.push_back({model_pc, mem_word(model_pc)});
            model_pc += 32'd4;
            grants++;
        end
        if (inst_valid_o && ready && !jump) begin
            if (pops == 0) begin
                first_pop_cyc  = cyc;
                first_pop_addr = inst_addr_o;
            end
            pops++;
            chk("exp_q_nonempty", {63'd0, exp_q.size() != 0}, 64'd1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("inst_addr", {32'd0, inst_addr_o}, {32'd0, e[63:32]});
                chk("inst", {32'd0, inst_o}, {32'd0, e[31:0]});
            end
        end else if (!inst_valid_o) begin
            chk("nop_when_empty", {32'd0, inst_o}, {32'd0, INST_NOP});
        end
        if (jump) begin
            exp_q.delete();
            model_pc = {jaddr[31:2], 2'b00};
        end
        @(posedge clk_i);
        @(negedge clk_i);
        cyc++;
    endtask

    task automatic run(input int n, input logic ready, input logic gnt);
        for (int i = 0; i < n; i++) cycle(1'b0, 32'h0, ready, gnt);
    endtask

    // Asserts reset at the current time, checks outputs, releases on a negedge.
    // The bus is reset alongside, so its pending responses are dropped.
    task automatic do_reset();
        rst_ni        = 1'b0;
        jump_flag_i   = 1'b0;
        jump_addr_i   = 32'h0;
        ibus_gnt_i    = 1'b0;
        ibus_rvalid_i = 1'b0;
        ibus_rdata_i  = 32'h0;
        inst_ready_i  = 1'b0;
        bus_q.delete();
        exp_q.delete();
        model_pc = 32'h0;
        #1;
        chk("rst_req",        {63'd0, ibus_req_o},   64'd0);
        chk("rst_addr",       {32'd0, ibus_addr_o},  64'd0);
        chk("rst_valid",      {63'd0, inst_valid_o}, 64'd0);
        chk("rst_inst",       {32'd0, inst_o},       {32'd0, INST_NOP});
        chk("rst_inst_addr",  {32'd0, inst_addr_o},  {32'd0, ZeroWord});
        repeat (2) @(negedge clk_i);
        rst_ni = 1'b1;
        cyc    = 0;
        grants = 0;
        pops   = 0;
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        resp_en = 1'b1;
        do_reset();

        // Streaming: one fetch per cycle, first instruction visible in cycle 2.
        run(10, 1'b1, 1'b1);
        chk("stream_grants",    grants,         64'd10);
        chk("stream_pops",      pops,           64'd8);
        chk("first_valid_cyc",  first_pop_cyc,  64'd2);
        chk("first_valid_addr", {32'd0, first_pop_addr}, 64'h0);

        // Decode stalled right after reset: only Depth fetches go out.
        do_reset();
        run(10, 1'b0, 1'b1);
        chk("stall_grants",   grants,                 64'd2);
        chk("stall_req_low",  {63'd0, ibus_req_o},    64'd0);
        chk("stall_valid",    {63'd0, inst_valid_o},  64'd1);
        chk("stall_head",     {32'd0, inst_addr_o},   64'h0);
        chk("stall_head_w",   {32'd0, inst_o},        {32'd0, mem_word(32'h0)});
        run(8, 1'b1, 1'b1);
        chk("stall_drain_first", {32'd0, first_pop_addr}, 64'h0);

        // Two requests in flight, then redirect to 0x100.
        resp_en = 1'b0;
        run(2, 1'b1, 1'b1);
        chk("two_outstanding", bus_q.size(), 64'd2);
        cycle(1'b1, 32'h0000_0100, 1'b1, 1'b1);
        resp_en = 1'b1;
        pops = 0;
        run(10, 1'b1, 1'b1);
        chk("jump_first_addr", {32'd0, first_pop_addr}, 64'h100);

        // Redirect coincident with a response and gnt, to an unaligned target.
        resp_en = 1'b0;
        run(2, 1'b1, 1'b1);
        resp_en = 1'b1;
        cycle(1'b1, 32'h0000_0203, 1'b1, 1'b1);
        pops = 0;
        run(10, 1'b1, 1'b1);
        chk("coinc_first_addr", {32'd0, first_pop_addr}, 64'h200);

        // Back-to-back redirects: the later target wins.
        cycle(1'b1, 32'h0000_0300, 1'b1, 1'b1);
        cycle(1'b1, 32'h0000_0404, 1'b1, 1'b1);
        pops = 0;
        run(10, 1'b1, 1'b1);
        chk("b2b_first_addr", {32'd0, first_pop_addr}, 64'h404);

        // Idle pipe, then redirect: issue, response, visible.
        run(3, 1'b1, 1'b0);
        chk("idle_bus_empty", bus_q.size(), 64'd0);
        jump_cyc = cyc;
        cycle(1'b1, 32'h0000_0500, 1'b1, 1'b1);
        pops = 0;
        run(6, 1'b1, 1'b1);
        chk("redirect_latency",  first_pop_cyc - jump_cyc, 64'd3);
        chk("redirect_addr",     {32'd0, first_pop_addr},  64'h500);

        // Reset with two requests outstanding.
        resp_en = 1'b0;
        run(2, 1'b1, 1'b1);
        chk("pre_reset_outstanding", bus_q.size(), 64'd2);
        do_reset();
        resp_en = 1'b1;
        run(6, 1'b1, 1'b1);
        chk("post_reset_first", {32'd0, first_pop_addr}, 64'h0);
        chk("post_reset_pops",  pops, 64'd4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
